cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Round-robin arbiter for the 32-bit common result bus (CDB) shared by four functional-unit result ports.
- Each cycle it grants at most one requesting unit and drives the 2-bit select that steers the downstream 4:1 result multiplexer.
- It registers the winning data and tag onto the CDB with a valid flag.
- It sits directly upstream of the result mux and of the reservation-station and register-file tag-match logic.

Parameters:
- TAG_W, 4, width of the reservation-station tag carried with each result.
- DATA_W, 32, result data width; must match the result mux width.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  per-unit result request; bit i = unit i.
- data_0..data_3  input  DATA_W  result data of unit i, valid while req[i]=1.
- tag_0..tag_3  input  TAG_W  tag of unit i, valid while req[i]=1.
- cdb_hold  input  1  downstream stall; no grant and CDB register frozen while 1.
- gnt  output  4  one-hot grant, combinational, same cycle as the request.
- sel  output  2  binary encode of gnt; drives the result mux select. Holds the last value when no grant.
- cdb_valid  output  1  registered: CDB carries a result this cycle.
- cdb_tag  output  TAG_W  registered winning tag.
- cdb_data  output  DATA_W  registered winning data.

Behaviour:
- Reset (rst_n=0, async):
  - ptr=0, sel=0, cdb_valid=0, cdb_tag=0, cdb_data=0.
  - gnt=0 while in reset.
- Priority pointer ptr[1:0] names the highest-priority unit. The search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- Grant rule (combinational):
  - If cdb_hold=0 and req!=0, gnt = one-hot of the first requesting unit in search order, else gnt=0.
  - sel = encode(gnt) when a grant is made, else the registered previous sel.
- Handshake:
  - A unit keeps req, data and tag stable until it sees gnt[i]=1 in a cycle.
  - The transfer completes on that clock edge.
  - The unit may present a new result (req still 1) in the next cycle.
- Pointer update on the edge after a grant to unit i: ptr <= (i+1) mod 4, wrapping 3 to 0. No grant: ptr unchanged.
- CDB register, latency 1 cycle from grant:
  - Grant: cdb_valid<=1, cdb_tag<=tag_i, cdb_data<=data_i.
  - No grant and cdb_hold=0: cdb_valid<=0; tag and data keep their old values.
  - cdb_hold=1: all CDB outputs and ptr are frozen.
- Simultaneous requests: exactly one grant per cycle. Under all-four-requesting for 4 cycles, each unit is granted exactly once (fairness bound 3 waiting cycles).
- Single requester: granted every cycle, back-to-back, with no bubble.
- cdb_hold rising mid-stream: the result latched the previous cycle stays on the CDB with cdb_valid held at 1 until hold drops.
- req dropped without a grant is a protocol violation. The arbiter simply re-evaluates and takes no other action.
- Reset asserted mid-transfer clears everything immediately. No in-flight result survives, and units must re-request.

Optional Feature:
- Macro: CDB_CONFLICT_CNT_EN.
- Defined:
  - Adds output conflict_cnt [15:0].
  - It increments (saturating at 16'hFFFF) on every edge where more than one req bit is set, or req!=0 while cdb_hold=1.
  - It resets to 0 on rst_n.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cdb_pkg:
  - NUM_FU=4, SEL_W=2, TAG_W default, DATA_W default.
  - FU index constants FU_ALU=0, FU_MUL=1, FU_LD=2, FU_BR=3.
- Sub-module rr_pick4: purely combinational rotate-priority-find. Inputs req[3:0] and ptr[1:0]; outputs onehot[3:0], idx[1:0], any.
- cdb_arbiter instantiates rr_pick4 and holds ptr, sel and the CDB registers.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with req=4'b1111 -> gnt=0, sel=0, cdb_valid=0 immediately; after release, first grant goes to unit 0.
- Round-robin with req=4'b1111 held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; sel 0,1,2,3,0; cdb_tag follows tag_i one cycle later.
- Pointer wrap: grant unit 3 (req=4'b1000), then req=4'b1001 -> unit 0 granted next, then unit 3.
- Back-to-back single unit: req=4'b0100 for 3 cycles with data 32'hA,B,C -> cdb_data A,B,C on consecutive cycles, cdb_valid=1 throughout, sel=2.
- Hold: cdb_data=32'h1234 valid, assert cdb_hold 2 cycles with req=4'b0011 -> gnt=0, CDB frozen at 32'h1234 and valid=1, ptr unchanged; after release unit 0 or 1 is granted per ptr.
- CDB_CONFLICT_CNT_EN defined: 5 cycles of req=4'b0110 -> conflict_cnt=5; preload near 16'hFFFF -> saturates, no wrap.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared constants for the CDB arbiter slice: unit count, select width,
// default tag/data widths and functional-unit indices.
package cdb_pkg;
    localparam int unsigned NUM_FU     = 4;
    localparam int unsigned SEL_W      = 2;
    localparam int unsigned CDB_TAG_W  = 4;
    localparam int unsigned CDB_DATA_W = 32;

    typedef enum logic [SEL_W-1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_LD  = 2'd2,
        FU_BR  = 2'd3
    } fu_e;
endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority find: first set bit of req searching
// ptr, ptr+1, ptr+2, ptr+3 (mod 4).
module rr_pick4
    import cdb_pkg::*;
(
    input  logic [NUM_FU-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_FU-1:0] onehot,
    output logic [SEL_W-1:0]  idx,
    output logic              any
);
    logic [SEL_W-1:0] w_cand;
    logic [SEL_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        w_cand  = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            w_cand = ptr + k[SEL_W-1:0];
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign idx    = w_idx;
    assign any    = w_found;
    assign onehot = w_found ? (NUM_FU'(1) << w_idx) : '0;
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: combinational grant/select, registered CDB output.
// Optional saturating conflict counter enabled by macro CDB_CONFLICT_CNT_EN.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned TAG_W  = CDB_TAG_W,
    parameter int unsigned DATA_W = CDB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] data_0,
    input  logic [DATA_W-1:0] data_1,
    input  logic [DATA_W-1:0] data_2,
    input  logic [DATA_W-1:0] data_3,
    input  logic [TAG_W-1:0]  tag_0,
    input  logic [TAG_W-1:0]  tag_1,
    input  logic [TAG_W-1:0]  tag_2,
    input  logic [TAG_W-1:0]  tag_3,
    input  logic              cdb_hold,
    output logic [3:0]        gnt,
    output logic [1:0]        sel,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_data
`ifdef CDB_CONFLICT_CNT_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);
    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  r_sel;
    logic              r_valid;
    logic [TAG_W-1:0]  r_tag;
    logic [DATA_W-1:0] r_data;

    logic [NUM_FU-1:0] w_onehot;
    logic [SEL_W-1:0]  w_idx;
    logic              w_any;
    logic              w_grant;
    logic [TAG_W-1:0]  w_win_tag;
    logic [DATA_W-1:0] w_win_data;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (r_ptr),
        .onehot (w_onehot),
        .idx    (w_idx),
        .any    (w_any)
    );

    // rst_n gates the grant so nothing is offered while reset is held
    assign w_grant = rst_n && !cdb_hold && w_any;
    assign gnt     = w_grant ? w_onehot : '0;
    assign sel     = w_grant ? w_idx : r_sel;

    always_comb begin
        w_win_tag  = tag_0;
        w_win_data = data_0;
        case (fu_e'(w_idx))
            FU_ALU: begin w_win_tag = tag_0; w_win_data = data_0; end
            FU_MUL: begin w_win_tag = tag_1; w_win_data = data_1; end
            FU_LD:  begin w_win_tag = tag_2; w_win_data = data_2; end
            FU_BR:  begin w_win_tag = tag_3; w_win_data = data_3; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (w_grant) begin
            r_ptr   <= w_idx + 2'd1;
            r_sel   <= w_idx;
            r_valid <= 1'b1;
            r_tag   <= w_win_tag;
            r_data  <= w_win_data;
        end else if (!cdb_hold) begin
            r_valid <= 1'b0;
        end
    end

    assign cdb_valid = r_valid;
    assign cdb_tag   = r_tag;
    assign cdb_data  = r_data;

`ifdef CDB_CONFLICT_CNT_EN
    logic [15:0] r_conflict_cnt;
    logic        w_conflict;

    assign w_conflict = ($countones(req) > 1) || ((req != '0) && cdb_hold);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
        end else if (w_conflict && (r_conflict_cnt != '1)) begin
            r_conflict_cnt <= r_conflict_cnt + 16'd1;
        end
    end

    assign conflict_cnt = r_conflict_cnt;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter; conflict counter checks
// compile in when CDB_CONFLICT_CNT_EN is defined.
module tb_cdb_arbiter;
    localparam logic [31:0] DATA_BASE = 32'hC0DE_0000;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_0, data_1, data_2, data_3;
    logic [3:0]  tag_0, tag_1, tag_2, tag_3;
    logic        cdb_hold;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_data;
`ifdef CDB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
`endif

    int errors = 0;
    int checks = 0;

    cdb_arbiter #(.TAG_W(4), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_0    (data_0),
        .data_1    (data_1),
        .data_2    (data_2),
        .data_3    (data_3),
        .tag_0     (tag_0),
        .tag_1     (tag_1),
        .tag_2     (tag_2),
        .tag_3     (tag_3),
        .cdb_hold  (cdb_hold),
        .gnt       (gnt),
        .sel       (sel),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
`ifdef CDB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic       hold;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] tag;
    } vec_t;

    vec_t vecs[19];

    initial begin
        // req, hold | gnt, sel (same cycle) | valid, tag (after the edge)
        vecs[0]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 4'hA};
        vecs[1]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 4'hB};
        vecs[2]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 4'hC};
        vecs[3]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 4'hD};
        vecs[4]  = '{4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1, 4'hA};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0010, 2'd1, 1'b1, 4'hB};
        vecs[6]  = '{4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 4'hC};
        vecs[7]  = '{4'b1111, 1'b0, 4'b1000, 2'd3, 1'b1, 4'hD};
        vecs[8]  = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1, 4'hD};
        vecs[9]  = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b1, 4'hA};
        vecs[10] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b1, 4'hD};
        vecs[11] = '{4'b0000, 1'b0, 4'b0000, 2'd3, 1'b0, 4'hD};
        vecs[12] = '{4'b0011, 1'b1, 4'b0000, 2'd3, 1'b0, 4'hD};
        vecs[13] = '{4'b0010, 1'b0, 4'b0010, 2'd1, 1'b1, 4'hB};
        vecs[14] = '{4'b0011, 1'b1, 4'b0000, 2'd1, 1'b1, 4'hB};
        vecs[15] = '{4'b0011, 1'b1, 4'b0000, 2'd1, 1'b1, 4'hB};
        vecs[16] = '{4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1, 4'hA};
        vecs[17] = '{4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 4'hB};
        vecs[18] = '{4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 4'hB};

        rst_n    = 1'b0;
        req      = 4'b1111;
        cdb_hold = 1'b0;
        tag_0 = 4'hA; tag_1 = 4'hB; tag_2 = 4'hC; tag_3 = 4'hD;
        data_0 = DATA_BASE + 32'd0; data_1 = DATA_BASE + 32'd1;
        data_2 = DATA_BASE + 32'd2; data_3 = DATA_BASE + 32'd3;

        #2;
        check("rst_gnt",   {28'd0, gnt}, 32'd0);
        check("rst_sel",   {30'd0, sel}, 32'd0);
        check("rst_valid", {31'd0, cdb_valid}, 32'd0);
        check("rst_tag",   {28'd0, cdb_tag}, 32'd0);
        check("rst_data",  cdb_data, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0000;

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            req      = vecs[i].req;
            cdb_hold = vecs[i].hold;
            #1;
            check($sformatf("v%0d_gnt", i), {28'd0, gnt}, {28'd0, vecs[i].gnt});
            check($sformatf("v%0d_sel", i), {30'd0, sel}, {30'd0, vecs[i].sel});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), {31'd0, cdb_valid}, {31'd0, vecs[i].valid});
            check($sformatf("v%0d_tag", i), {28'd0, cdb_tag}, {28'd0, vecs[i].tag});
            check($sformatf("v%0d_data", i), cdb_data,
                  DATA_BASE + {28'd0, vecs[i].tag - 4'hA});
        end

        // Back-to-back single requester, new data every cycle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req    = 4'b0100;
            data_2 = 32'hA + i;
            #1;
            check($sformatf("b2b%0d_gnt", i), {28'd0, gnt}, 32'b0100);
            check($sformatf("b2b%0d_sel", i), {30'd0, sel}, 32'd2);
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d_valid", i), {31'd0, cdb_valid}, 32'd1);
            check($sformatf("b2b%0d_data", i), cdb_data, 32'hA + i);
        end

        // Hold freezes a valid result; ptr stays at 1 after granting unit 0
        @(negedge clk);
        req    = 4'b0001;
        data_0 = 32'h1234;
        #1;
        check("hpre_gnt", {28'd0, gnt}, 32'b0001);
        @(posedge clk);
        #1;
        check("hpre_data", cdb_data, 32'h1234);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            req      = 4'b0011;
            cdb_hold = 1'b1;
            #1;
            check($sformatf("hold%0d_gnt", i), {28'd0, gnt}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("hold%0d_valid", i), {31'd0, cdb_valid}, 32'd1);
            check($sformatf("hold%0d_data", i), cdb_data, 32'h1234);
        end
        @(negedge clk);
        cdb_hold = 1'b0;
        #1;
        check("hrel_gnt", {28'd0, gnt}, 32'b0010);
        check("hrel_sel", {30'd0, sel}, 32'd1);
        @(posedge clk);
        #1;
        check("hrel_tag", {28'd0, cdb_tag}, 32'hB);

        // Reset asserted in the middle of a cycle with everyone requesting
        @(negedge clk);
        req = 4'b1111;
        #1;
        check("mid_pre_any", {31'd0, gnt != 4'b0000}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_gnt",   {28'd0, gnt}, 32'd0);
        check("mid_sel",   {30'd0, sel}, 32'd0);
        check("mid_valid", {31'd0, cdb_valid}, 32'd0);
        check("mid_data",  cdb_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rel_gnt", {28'd0, gnt}, 32'b0001);
        check("mid_rel_sel", {30'd0, sel}, 32'd0);

`ifdef CDB_CONFLICT_CNT_EN
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        check("cc_rst", {16'd0, conflict_cnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0110;
        repeat (5) @(posedge clk);
        #1;
        check("cc_five", {16'd0, conflict_cnt}, 32'd5);
        repeat (65535) @(posedge clk);
        #1;
        check("cc_sat", {16'd0, conflict_cnt}, 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
